uart_rx_capture_mc: RTL and testbench
=====================================

// Module: uart_rx_capture_mc
// PURPOSE
//  Parametrised multi-channel UART receiver for the PULPino simulation and FPGA environments.
//  Successor to the fixed 8N1 single-channel bus model: it supports N channels,
//  configurable baud rate and data width, an optional parity check, and per-channel capture FIFOs.
//  Sits beside pulpino_top on the uart_tx pad(s) and buffers core console output for bench
//  checkers or a host readout path. Fully synthesizable.
// PARAMETERS
//  NUM_CH        2           number of independent UART receive channels (1..8)
//  CLKS_PER_BIT  32          clk cycles per UART bit (100 MHz / 3.125 Mbaud); must be >= 4
//  DATA_BITS     8           payload bits per frame (5..8), sent LSB first
//  FIFO_DEPTH    16          entries per channel FIFO; power of two, >= 2
// PORTS
//  clk          in   1                 system clock, all logic on rising edge
//  rst          in   1                 reset, asynchronous, active-high
//  rx_i         in   NUM_CH            serial inputs, idle high, asynchronous to clk
//  data_o       out  NUM_CH*DATA_BITS  head-of-FIFO byte per channel, ch k at [k*DATA_BITS +: DATA_BITS]
//  valid_o      out  NUM_CH            channel FIFO non-empty
//  ready_i      in   NUM_CH            pop request; pop occurs on valid_o & ready_i
//  level_o      out  NUM_CH*($clog2(FIFO_DEPTH)+1)  entries held per channel
//  frame_err_o  out  NUM_CH            sticky: stop bit sampled low
//  parity_err_o out  NUM_CH            sticky: parity mismatch (0 when UART_PARITY_EN undefined)
//  overflow_o   out  NUM_CH            sticky: byte dropped because FIFO full
//  clear_i      in   NUM_CH            synchronous clear of that channel's sticky flags
// BEHAVIOUR
//  - Reset: all outputs 0, data_o 0, FSMs IDLE, FIFOs empty, synchronisers preset to 1.
//  - Reset is asynchronous and active-high. Asserting it mid-frame aborts the frame. The first
//    start bit is accepted only after the synchronised line has been seen high for at least 1 cycle.
//  - rx_i passes through a 2-flop synchroniser; all decisions use the synchronised value.
//  - Per-channel FSM:
//    IDLE -> START on a 1->0 edge.
//    START: at CLKS_PER_BIT/2 recheck the line. If low, go to DATA. If high, treat it as a
//      glitch and return to IDLE; no flag is set.
//    DATA: sample every CLKS_PER_BIT cycles; DATA_BITS samples, LSB first.
//    PARITY (only with UART_PARITY_EN): one more sample.
//    STOP: one sample. If high, push the byte; if low, set frame_err and drop the byte.
//    After STOP the FSM goes to IDLE if the line is high, else to BREAK.
//    BREAK: wait for the line to go high, then go to IDLE. This covers a line held low.
//  - Bit counter width is $clog2(CLKS_PER_BIT); it resets at each sample point.
//    Sampling is always mid-bit.
//  - Latency: push occurs in the cycle after the stop-bit sample. valid_o/data_o update on the
//    next clk edge (registered head).
//  - FIFO rules:
//    Pop on valid_o & ready_i; ready_i is ignored while empty.
//    Push while full and no pop: set overflow and drop the byte; contents are unchanged.
//    Simultaneous push and pop while full: both succeed, level unchanged, no overflow.
//    Simultaneous push and pop while empty: the push succeeds; the pop is ignored.
//    Pointers wrap modulo FIFO_DEPTH.
//  - Sticky flags: set and clear in the same cycle resolves to set. Flags never clear on reset
//    release alone; they are 0 because reset cleared them.
//  - Channels are fully independent. There is no cross-channel arbitration.
// CONFIGURATION
//  UART_PARITY_EN defined:
//    Frames carry an even-parity bit after the data bits.
//    Mismatch sets parity_err_o and the byte is still pushed.
//    A frame with both a parity error and a framing error is dropped; both flags are set.
//  UART_PARITY_EN undefined:
//    No parity state. Frame is start + DATA_BITS + stop.
//    parity_err_o is tied to 0.
// TESTING
//  T1 ch0 sends 8'h65 at 32 clk/bit, ready_i=1 -> valid_o[0] one cycle, data 8'h65, all flags 0
//  T2 ch0 and ch1 simultaneously send 8'hA5 / 8'h3C -> each channel captures its own byte;
//     no crosstalk
//  T3 ready_i=0, 17 bytes 0..16 on ch0 -> level_o=16, overflow_o[0]=1;
//     pops return 0..15 in order, byte 16 lost
//  T4 stop bit forced low on 8'h55 -> frame_err_o=1, level unchanged;
//     line low 40 bit times then 8'h0F -> 8'h0F captured; clear_i drops flag
//  T5 10-cycle low glitch on idle line -> no push, no flags;
//     reset asserted mid-DATA -> outputs 0, next full frame received correctly
//  T6 (UART_PARITY_EN) 8'h07 with odd parity bit -> byte pushed, parity_err_o=1;
//     correct parity -> flag unchanged

Source files
------------

// File: rtl/uart_rx_capture_mc.sv
//==============================================================================
// Module   : uart_rx_capture_mc
// Brief    : N-channel UART receiver with per-channel capture FIFOs and sticky
//            error flags. Define UART_PARITY_EN to add an even-parity bit.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_capture_mc #(
    parameter int NUM_CH       = 2,
    parameter int CLKS_PER_BIT = 32,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_CH-1:0]                        rx_i,
    output logic [NUM_CH*DATA_BITS-1:0]              data_o,
    output logic [NUM_CH-1:0]                        valid_o,
    input  logic [NUM_CH-1:0]                        ready_i,
    output logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0] level_o,
    output logic [NUM_CH-1:0]                        frame_err_o,
    output logic [NUM_CH-1:0]                        parity_err_o,
    output logic [NUM_CH-1:0]                        overflow_o,
    input  logic [NUM_CH-1:0]                        clear_i
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [1:0]           sync_q;
        logic                 w_rx;
        logic                 prev_q;
        state_t               state_q;
        logic [CW-1:0]        cnt_q;
        logic [BW-1:0]        bit_q;
        logic [DATA_BITS-1:0] shift_q;
        logic                 push_q;
        logic                 ferr_set_q;
        logic                 ferr_q;
        logic                 ovf_q;
`ifdef UART_PARITY_EN
        logic                 par_q;
        logic                 perr_set_q;
        logic                 perr_q;
`endif

        logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
        logic [AW-1:0]        wr_q;
        logic [AW-1:0]        rd_q;
        logic [AW-1:0]        w_rd_nxt;
        logic [LW-1:0]        count_q;
        logic [DATA_BITS-1:0] head_q;
        logic                 w_empty;
        logic                 w_full;
        logic                 w_pop;
        logic                 w_push;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= 2'b11;
            end else begin
                sync_q <= {sync_q[0], rx_i[g]};
            end
        end
        assign w_rx = sync_q[1];

        // prev_q resets low so a start edge needs the line seen high first.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q    <= S_IDLE;
                prev_q     <= 1'b0;
                cnt_q      <= '0;
                bit_q      <= '0;
                shift_q    <= '0;
                push_q     <= 1'b0;
                ferr_set_q <= 1'b0;
`ifdef UART_PARITY_EN
                par_q      <= 1'b0;
                perr_set_q <= 1'b0;
`endif
            end else begin
                prev_q     <= w_rx;
                push_q     <= 1'b0;
                ferr_set_q <= 1'b0;
`ifdef UART_PARITY_EN
                perr_set_q <= 1'b0;
`endif
                case (state_q)
                    S_IDLE: begin
                        cnt_q <= '0;
                        if (prev_q && !w_rx) state_q <= S_START;
                    end
                    S_START: begin
                        if (cnt_q == HALF_M1) begin
                            cnt_q   <= '0;
                            bit_q   <= '0;
                            state_q <= w_rx ? S_IDLE : S_DATA;
`ifdef UART_PARITY_EN
                            par_q   <= 1'b0;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (cnt_q == FULL_M1) begin
                            cnt_q   <= '0;
                            shift_q <= {w_rx, shift_q[DATA_BITS-1:1]};
`ifdef UART_PARITY_EN
                            par_q   <= par_q ^ w_rx;
`endif
                            if (bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                                state_q <= S_PARITY;
`else
                                state_q <= S_STOP;
`endif
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
`ifdef UART_PARITY_EN
                    S_PARITY: begin
                        if (cnt_q == FULL_M1) begin
                            cnt_q   <= '0;
                            par_q   <= par_q ^ w_rx;
                            state_q <= S_STOP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
`endif
                    S_STOP: begin
                        if (cnt_q == FULL_M1) begin
                            cnt_q      <= '0;
                            push_q     <= w_rx;
                            ferr_set_q <= ~w_rx;
`ifdef UART_PARITY_EN
                            perr_set_q <= par_q;
`endif
                            state_q    <= w_rx ? S_IDLE : S_BREAK;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_BREAK: begin
                        if (w_rx) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end

        assign w_empty  = (count_q == '0);
        assign w_full   = (count_q == LW'(FIFO_DEPTH));
        assign w_pop    = ~w_empty & ready_i[g];
        assign w_push   = push_q & (~w_full | w_pop);
        assign w_rd_nxt = rd_q + 1'b1;

        // shift_q stays stable until the next frame's first data sample.
        always_ff @(posedge clk) begin
            if (w_push) mem_q[wr_q] <= shift_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_q    <= '0;
                rd_q    <= '0;
                count_q <= '0;
                head_q  <= '0;
            end else begin
                if (w_push) wr_q <= wr_q + 1'b1;
                if (w_pop)  rd_q <= w_rd_nxt;
                count_q <= count_q + LW'(w_push) - LW'(w_pop);
                if (w_push && (w_empty || (w_pop && count_q == LW'(1))))
                    head_q <= shift_q;
                else if (w_pop)
                    head_q <= mem_q[w_rd_nxt];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ferr_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                if (ferr_set_q)                  ferr_q <= 1'b1;
                else if (clear_i[g])             ferr_q <= 1'b0;
                if (push_q && w_full && !w_pop)  ovf_q  <= 1'b1;
                else if (clear_i[g])             ovf_q  <= 1'b0;
            end
        end

`ifdef UART_PARITY_EN
        always_ff @(posedge clk or posedge rst) begin
            if (rst)              perr_q <= 1'b0;
            else if (perr_set_q)  perr_q <= 1'b1;
            else if (clear_i[g])  perr_q <= 1'b0;
        end
        assign parity_err_o[g] = perr_q;
`else
        assign parity_err_o[g] = 1'b0;
`endif

        assign data_o[g*DATA_BITS +: DATA_BITS] = head_q;
        assign valid_o[g]                       = ~w_empty;
        assign level_o[g*LW +: LW]              = count_q;
        assign frame_err_o[g]                   = ferr_q;
        assign overflow_o[g]                    = ovf_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_capture_mc.sv
//==============================================================================
// Module   : tb_uart_rx_capture_mc
// Brief    : directed + randomized bench for uart_rx_capture_mc with a
//            queue-based reference model.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_capture_mc;

    localparam int NCH   = 2;
    localparam int CPB   = 32;
    localparam int DB    = 8;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [NCH-1:0]     rx;
    logic [NCH*DB-1:0]  data_o;
    logic [NCH-1:0]     valid_o;
    logic [NCH-1:0]     ready;
    logic [NCH*LW-1:0]  level_o;
    logic [NCH-1:0]     frame_err_o;
    logic [NCH-1:0]     parity_err_o;
    logic [NCH-1:0]     overflow_o;
    logic [NCH-1:0]     clear;

    int checks   = 0;
    int failures = 0;

    logic [7:0]     mq0[$];
    logic [7:0]     mq1[$];
    logic [NCH-1:0] exp_ferr = '0;
    logic [NCH-1:0] exp_perr = '0;
    logic [NCH-1:0] exp_ovf  = '0;

    uart_rx_capture_mc #(
        .NUM_CH(NCH), .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rx_i(rx), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready), .level_o(level_o), .frame_err_o(frame_err_o),
        .parity_err_o(parity_err_o), .overflow_o(overflow_o), .clear_i(clear)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int ch);
        return (ch == 0) ? mq0.size() : mq1.size();
    endfunction

    // Frame outcome from the receive rules: bad stop drops, full FIFO drops with overflow.
    function automatic void model_frame(input int ch, input logic [7:0] d,
                                        input logic stop_ok, input logic par_ok);
        if (!par_ok) exp_perr[ch] = 1'b1;
        if (!stop_ok)                exp_ferr[ch] = 1'b1;
        else if (qsize(ch) >= DEPTH) exp_ovf[ch]  = 1'b1;
        else if (ch == 0)            mq0.push_back(d);
        else                         mq1.push_back(d);
    endfunction

    task automatic send(input int ch, input logic [7:0] d, input logic stop_v, input logic pflip);
        rx[ch] = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx[ch] = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx[ch] = (^d) ^ pflip;
        repeat (CPB) @(negedge clk);
`else
        if (pflip) rx[ch] = 1'b1;
`endif
        rx[ch] = stop_v;
        repeat (CPB) @(negedge clk);
        rx[ch] = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_ferr"}, 32'(frame_err_o),  32'(exp_ferr));
        chk({tag, "_perr"}, 32'(parity_err_o), 32'(exp_perr));
        chk({tag, "_ovf"},  32'(overflow_o),   32'(exp_ovf));
    endtask

    task automatic chk_level(input string tag, input int ch);
        chk({tag, "_level"}, 32'(level_o[ch*LW +: LW]), 32'(qsize(ch)));
    endtask

    task automatic drain(input string tag, input int ch);
        int n;
        logic [7:0] e;
        n = qsize(ch);
        for (int i = 0; i < n; i++) begin
            e = (ch == 0) ? mq0.pop_front() : mq1.pop_front();
            chk({tag, "_valid"}, 32'(valid_o[ch]), 32'd1);
            chk({tag, "_data"},  32'(data_o[ch*DB +: DB]), 32'(e));
            ready[ch] = 1'b1;
            @(negedge clk);
            ready[ch] = 1'b0;
        end
        chk({tag, "_empty"}, 32'(valid_o[ch]), 32'd0);
        chk_level(tag, ch);
    endtask

    task automatic do_clear(input int ch);
        clear[ch] = 1'b1;
        @(negedge clk);
        clear[ch] = 1'b0;
        exp_ferr[ch] = 1'b0;
        exp_perr[ch] = 1'b0;
        exp_ovf[ch]  = 1'b0;
    endtask

    initial begin
        logic [7:0] d0, d1;
        logic       s0, s1;
        int         n;

        rst = 1'b1; rx = '1; ready = '0; clear = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data",  32'(data_o),  32'd0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk_flags("rst");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // T1: single byte with ready held high -> one-cycle valid pulse
        ready[0] = 1'b1;
        fork
            send(0, 8'h65, 1'b1, 1'b0);
            begin
                n = 0;
                while (!valid_o[0] && n < 1000) begin @(negedge clk); n++; end
                chk("t1_valid", 32'(valid_o[0]), 32'd1);
                chk("t1_data",  32'(data_o[7:0]), 32'h65);
                @(negedge clk);
                chk("t1_pulse", 32'(valid_o[0]), 32'd0);
            end
        join
        ready[0] = 1'b0;
        chk_flags("t1");
        chk_level("t1", 0);

        // T2: simultaneous traffic, directed then randomized
        fork
            send(0, 8'hA5, 1'b1, 1'b0);
            send(1, 8'h3C, 1'b1, 1'b0);
        join
        model_frame(0, 8'hA5, 1'b1, 1'b1);
        model_frame(1, 8'h3C, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            d0 = 8'($urandom); d1 = 8'($urandom);
            s0 = ($urandom_range(0, 3) != 0);
            s1 = ($urandom_range(0, 3) != 0);
            fork
                send(0, d0, s0, 1'b0);
                send(1, d1, s1, 1'b0);
            join
            model_frame(0, d0, s0, 1'b1);
            model_frame(1, d1, s1, 1'b1);
        end
        chk_flags("t2");
        chk_level("t2_ch0", 0);
        chk_level("t2_ch1", 1);
        drain("t2_ch0", 0);
        drain("t2_ch1", 1);
        do_clear(0); do_clear(1);
        chk_flags("t2_clr");

        // T3: 17 bytes into a 16-deep FIFO
        for (int k = 0; k < 17; k++) begin
            send(0, 8'(k), 1'b1, 1'b0);
            model_frame(0, 8'(k), 1'b1, 1'b1);
        end
        chk("t3_level", 32'(level_o[LW-1:0]), 32'd16);
        chk_flags("t3");
        drain("t3", 0);
        do_clear(0);
        chk_flags("t3_clr");

        // T4: framing error, long break, recovery, clear
        d0 = 8'($urandom);
        send(0, d0, 1'b1, 1'b0);
        model_frame(0, d0, 1'b1, 1'b1);
        send(0, 8'h55, 1'b0, 1'b0);
        model_frame(0, 8'h55, 1'b0, 1'b1);
        chk_flags("t4_bad");
        chk_level("t4_bad", 0);
        rx[0] = 1'b0;
        repeat (40*CPB) @(negedge clk);
        rx[0] = 1'b1;
        repeat (2*CPB) @(negedge clk);
        model_frame(0, 8'h00, 1'b0, 1'b1);
        send(0, 8'h0F, 1'b1, 1'b0);
        model_frame(0, 8'h0F, 1'b1, 1'b1);
        chk_flags("t4_brk");
        drain("t4", 0);
        do_clear(0);
        chk_flags("t4_clr");

        // T5: glitch rejection, then reset mid-frame
        rx[0] = 1'b0;
        repeat (10) @(negedge clk);
        rx[0] = 1'b1;
        repeat (3*CPB) @(negedge clk);
        chk_level("t5_glitch", 0);
        chk_flags("t5_glitch");
        d0 = 8'($urandom);
        send(0, d0, 1'b1, 1'b0);
        model_frame(0, d0, 1'b1, 1'b1);
        send(1, 8'($urandom), 1'b0, 1'b0);
        d1 = 8'($urandom);
        rx[0] = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx[0] = d1[i];
            repeat (CPB) @(negedge clk);
        end
        #1 rst = 1'b1;
        #1;
        mq0.delete(); mq1.delete();
        exp_ferr = '0; exp_perr = '0; exp_ovf = '0;
        chk("t5_rst_valid", 32'(valid_o), 32'd0);
        chk("t5_rst_data",  32'(data_o),  32'd0);
        chk("t5_rst_level", 32'(level_o), 32'd0);
        chk_flags("t5_rst");
        rx[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (CPB) @(negedge clk);
        d0 = 8'($urandom);
        send(0, d0, 1'b1, 1'b0);
        model_frame(0, d0, 1'b1, 1'b1);
        chk_level("t5_after", 0);
        chk_flags("t5_after");
        drain("t5", 0);

`ifdef UART_PARITY_EN
        // T6: bad parity still pushes; good parity leaves the sticky flag set
        send(0, 8'h07, 1'b1, 1'b1);
        model_frame(0, 8'h07, 1'b1, 1'b0);
        chk_flags("t6_bad");
        send(0, 8'h07, 1'b1, 1'b0);
        model_frame(0, 8'h07, 1'b1, 1'b1);
        chk_flags("t6_good");
        drain("t6", 0);
        send(0, 8'h5A, 1'b0, 1'b1);
        model_frame(0, 8'h5A, 1'b0, 1'b0);
        chk_flags("t6_both");
        chk_level("t6_both", 0);
        do_clear(0);
        chk_flags("t6_clr");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
